// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
package imem_arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned KSEG_BIT = 31;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DEBUG = 2'd2
  } gnt_state_t;

  // Misaligned word or an address outside the kernel segment.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00) || !addr[KSEG_BIT];
  endfunction

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry response holding register; flush beats load, load beats drain.
module imem_rsp_slot
  import imem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] data,
  input  logic               err,
  input  logic               flush,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic               rsp_err
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_instr <= err ? NOP : data;
      rsp_err   <= err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single ROM read port between fetch and debug, one access per cycle,
// with a bounded-wait priority boost for debug.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               f_req_valid,
  output logic               f_req_ready,
  input  logic [ADDR_W-1:0]  f_req_addr,
  output logic               f_rsp_valid,
  input  logic               f_rsp_ready,
  output logic [INSTR_W-1:0] f_rsp_instr,
  output logic               f_rsp_err,
  input  logic               f_flush,
  input  logic               d_req_valid,
  output logic               d_req_ready,
  input  logic [ADDR_W-1:0]  d_req_addr,
  output logic               d_rsp_valid,
  input  logic               d_rsp_ready,
  output logic [INSTR_W-1:0] d_rsp_instr,
  output logic               d_rsp_err,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output gnt_state_t         gnt_state
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic              f_gnt;
  logic              d_gnt;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [WAIT_W-1:0] wait_cnt;
  gnt_state_t        gnt_state_nxt;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    logic f_elig;
    logic d_elig;
    f_gnt         = 1'b0;
    d_gnt         = 1'b0;
    acc_addr      = '0;
    gnt_state_nxt = IDLE;
    f_elig = reset && f_req_valid && !f_flush && (!f_rsp_valid || f_rsp_ready);
    d_elig = reset && d_req_valid && (!d_rsp_valid || d_rsp_ready);
    d_gnt  = d_elig && (!f_elig || (wait_cnt >= WAIT_LIMIT));
    f_gnt  = f_elig && !d_gnt;
    if (f_gnt) begin
      acc_addr      = f_req_addr;
      gnt_state_nxt = FETCH;
    end else if (d_gnt) begin
      acc_addr      = d_req_addr;
      gnt_state_nxt = DEBUG;
    end
  end

  assign f_req_ready = f_gnt;
  assign d_req_ready = d_gnt;
  assign acc_err     = addr_err(acc_addr);
  assign rom_addr    = {acc_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_state <= IDLE;
    end else begin
      gnt_state <= gnt_state_nxt;
    end
  end

  // Counts consecutive cycles a valid debug request goes unserved.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!d_req_valid || d_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != '1) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  imem_rsp_slot u_f_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (f_gnt),
    .data      (rom_instr),
    .err       (acc_err),
    .flush     (f_flush),
    .rsp_valid (f_rsp_valid),
    .rsp_ready (f_rsp_ready),
    .rsp_instr (f_rsp_instr),
    .rsp_err   (f_rsp_err)
  );

  imem_rsp_slot u_d_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (d_gnt),
    .data      (rom_instr),
    .err       (acc_err),
    .flush     (1'b0),
    .rsp_valid (d_rsp_valid),
    .rsp_ready (d_rsp_ready),
    .rsp_instr (d_rsp_instr),
    .rsp_err   (d_rsp_err)
  );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small combinational ROM model.
module tb_imem_port_arbiter;
  import imem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err, f_flush;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] f_req_addr, d_req_addr, f_rsp_instr, d_rsp_instr, rom_addr, rom_instr;
  gnt_state_t  gnt_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_instr(f_rsp_instr),
    .f_rsp_err(f_rsp_err), .f_flush(f_flush),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_instr(d_rsp_instr),
    .d_rsp_err(d_rsp_err),
    .rom_addr(rom_addr), .rom_instr(rom_instr), .gnt_state(gnt_state)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h3C08_4000;
      32'h8000_0004: return 32'h8D09_0020;
      default:       return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  always_comb rom_instr = rom_f(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f_req_valid = 1'b1; f_req_addr = 32'h8000_0000;
    d_req_valid = 1'b1; d_req_addr = 32'h8000_0100;
    #2;
    checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_f_rsp_valid got=%b exp=0", f_rsp_valid); end
    checks++; if (d_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_d_rsp_valid got=%b exp=0", d_rsp_valid); end
    checks++; if (f_rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_f_rsp_instr got=%h exp=0", f_rsp_instr); end
    checks++; if (f_req_ready !== 1'b0) begin errors++; $display("FAIL reset_f_req_ready got=%b exp=0", f_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL reset_d_req_ready got=%b exp=0", d_req_ready); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (gnt_state !== IDLE) begin errors++; $display("FAIL reset_gnt_state got=%0d exp=%0d", gnt_state, IDLE); end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_basic_fetch();
    f_rsp_ready = 1'b1; f_req_valid = 1'b1; f_req_addr = 32'h8000_0000;
    #1;
    checks++; if (f_req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", f_req_ready); end
    checks++; if (rom_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_rom_addr got=%h exp=80000000", rom_addr); end
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0 got=%b exp=1", f_rsp_valid); end
    checks++; if (f_rsp_instr !== 32'h3C08_4000) begin errors++; $display("FAIL basic_instr0 got=%h exp=3c084000", f_rsp_instr); end
    checks++; if (f_rsp_err !== 1'b0) begin errors++; $display("FAIL basic_err0 got=%b exp=0", f_rsp_err); end
    checks++; if (gnt_state !== FETCH) begin errors++; $display("FAIL basic_state got=%0d exp=%0d", gnt_state, FETCH); end
    f_req_addr = 32'h8000_0004;
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got=%b exp=1", f_rsp_valid); end
    checks++; if (f_rsp_instr !== 32'h8D09_0020) begin errors++; $display("FAIL basic_instr1 got=%h exp=8d090020", f_rsp_instr); end
    f_req_valid = 1'b0;
    tick();
    checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", f_rsp_valid); end
    checks++; if (gnt_state !== IDLE) begin errors++; $display("FAIL basic_idle got=%0d exp=%0d", gnt_state, IDLE); end
  endtask

  task automatic test_errors();
    f_req_valid = 1'b1; f_req_addr = 32'h0000_0000;
    tick();
    checks++; if (f_rsp_err !== 1'b1) begin errors++; $display("FAIL err_kseg_err got=%b exp=1", f_rsp_err); end
    checks++; if (f_rsp_instr !== 32'h0) begin errors++; $display("FAIL err_kseg_instr got=%h exp=0", f_rsp_instr); end
    f_req_addr = 32'h8000_0002;
    #1;
    checks++; if (rom_addr !== 32'h8000_0000) begin errors++; $display("FAIL err_align_rom_addr got=%h exp=80000000", rom_addr); end
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL err_align_valid got=%b exp=1", f_rsp_valid); end
    checks++; if (f_rsp_err !== 1'b1) begin errors++; $display("FAIL err_align_err got=%b exp=1", f_rsp_err); end
    checks++; if (f_rsp_instr !== 32'h0) begin errors++; $display("FAIL err_align_instr got=%h exp=0", f_rsp_instr); end
    f_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    f_req_valid = 1'b1; f_req_addr = 32'h8000_0010; f_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_addr = 32'h8000_0100; d_rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (d_req_ready !== (i % 5 == 4)) begin errors++; $display("FAIL cont_d_ready cyc=%0d got=%b exp=%b", i, d_req_ready, (i % 5 == 4)); end
      checks++; if (f_req_ready !== (i % 5 != 4)) begin errors++; $display("FAIL cont_f_ready cyc=%0d got=%b exp=%b", i, f_req_ready, (i % 5 != 4)); end
      checks++; if (dut.wait_cnt !== 3'(i % 5)) begin errors++; $display("FAIL cont_wait_cnt cyc=%0d got=%0d exp=%0d", i, dut.wait_cnt, i % 5); end
      tick();
      if (i == 4) begin
        checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_d_valid got=%b exp=1", d_rsp_valid); end
        checks++; if (d_rsp_instr !== rom_f(32'h8000_0100)) begin errors++; $display("FAIL cont_d_instr got=%h exp=%h", d_rsp_instr, rom_f(32'h8000_0100)); end
        checks++; if (gnt_state !== DEBUG) begin errors++; $display("FAIL cont_state got=%0d exp=%0d", gnt_state, DEBUG); end
      end
    end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 32'h8000_0020;
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_fill got=%b exp=1", f_rsp_valid); end
    f_req_addr = 32'h8000_0024;
    d_req_valid = 1'b1; d_req_addr = 32'h8000_0200; d_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (f_req_ready !== 1'b0) begin errors++; $display("FAIL bp_f_ready cyc=%0d got=%b exp=0", k, f_req_ready); end
      checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL bp_d_ready cyc=%0d got=%b exp=1", k, d_req_ready); end
      tick();
      checks++; if (f_rsp_valid !== 1'b1 || f_rsp_instr !== rom_f(32'h8000_0020)) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", k, f_rsp_valid, f_rsp_instr, rom_f(32'h8000_0020));
      end
    end
    f_rsp_ready = 1'b1;
    #1;
    checks++; if (f_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_f got=%b exp=1", f_req_ready); end
    checks++; if (d_req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_d got=%b exp=0", d_req_ready); end
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got=%b exp=1", f_rsp_valid); end
    checks++; if (f_rsp_instr !== rom_f(32'h8000_0024)) begin errors++; $display("FAIL bp_reload_instr got=%h exp=%h", f_rsp_instr, rom_f(32'h8000_0024)); end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    d_rsp_ready = 1'b0; d_req_valid = 1'b1; d_req_addr = 32'h8000_0300;
    tick();
    d_req_valid = 1'b0;
    f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 32'h8000_0030;
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_fill got=%b exp=1", f_rsp_valid); end
    f_flush = 1'b1; f_req_addr = 32'h8000_0034;
    #1;
    checks++; if (f_req_ready !== 1'b0) begin errors++; $display("FAIL flush_f_ready got=%b exp=0", f_req_ready); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL flush_rom_addr got=%h exp=0", rom_addr); end
    tick();
    checks++; if (f_rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_f_valid got=%b exp=0", f_rsp_valid); end
    checks++; if (d_rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_d_valid got=%b exp=1", d_rsp_valid); end
    checks++; if (d_rsp_instr !== rom_f(32'h8000_0300)) begin errors++; $display("FAIL flush_d_instr got=%h exp=%h", d_rsp_instr, rom_f(32'h8000_0300)); end
    f_flush = 1'b0;
    tick();
    checks++; if (f_rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_refill got=%b exp=1", f_rsp_valid); end
  endtask

  task automatic test_reset_mid();
    f_req_addr = 32'h8000_0040; d_req_valid = 1'b1; d_req_addr = 32'h8000_0400;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (f_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b/%b exp=0/0", f_rsp_valid, d_rsp_valid); end
    checks++; if (f_rsp_instr !== 32'h0 || d_rsp_instr !== 32'h0) begin errors++; $display("FAIL rmid_instr got=%h/%h exp=0/0", f_rsp_instr, d_rsp_instr); end
    checks++; if (f_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%b/%b exp=0/0", f_req_ready, d_req_ready); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL rmid_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (gnt_state !== IDLE) begin errors++; $display("FAIL rmid_state got=%0d exp=%0d", gnt_state, IDLE); end
    #1;
    reset = 1'b1; f_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    #1;
    checks++; if (f_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin errors++; $display("FAIL rmid_first_gnt got=%b/%b exp=1/0", f_req_ready, d_req_ready); end
    checks++; if (rom_addr !== 32'h8000_0040) begin errors++; $display("FAIL rmid_first_addr got=%h exp=80000040", rom_addr); end
    tick();
    checks++; if (f_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid got=%b/%b exp=1/0", f_rsp_valid, d_rsp_valid); end
    checks++; if (f_rsp_instr !== rom_f(32'h8000_0040)) begin errors++; $display("FAIL rmid_after_instr got=%h exp=%h", f_rsp_instr, rom_f(32'h8000_0040)); end
    f_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    f_req_valid = 1'b0; f_req_addr = '0; f_rsp_ready = 1'b0; f_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_rsp_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_errors();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single combinational instruction-ROM read port between the CPU fetch stage and a debug/loader read requester. Arbitrates one access per cycle, registers the ROM word into a per-requester one-entry response slot, and flags misaligned or non-kernel addresses. Sits between the PC/fetch logic and `InstructionMemory`, whose `Address`/`Instruction` pins it drives and samples.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive cycles a pending debug request may lose to fetch before it wins priority; legal range 1..7.
- `WAIT_W`, default 3: width of the debug wait counter; must satisfy 2^`WAIT_W` - 1 >= `MAX_WAIT`.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req_valid` in 1, `f_req_ready` out 1, `f_req_addr` in 32: fetch request.
- `f_rsp_valid` out 1, `f_rsp_ready` in 1, `f_rsp_instr` out 32, `f_rsp_err` out 1: fetch response.
- `f_flush` in 1: cancels the fetch response slot and suppresses a same-cycle fetch grant.
- `d_req_valid` in 1, `d_req_ready` out 1, `d_req_addr` in 32: debug request.
- `d_rsp_valid` out 1, `d_rsp_ready` in 1, `d_rsp_instr` out 32, `d_rsp_err` out 1: debug response.
- `rom_addr` out 32: drives the ROM `Address` input.
- `rom_instr` in 32: the ROM `Instruction` output, combinational from `rom_addr`.

## Operation
- Slot free for requester X: `X_rsp_valid`=0, or `X_rsp_ready`=1 this cycle.
- Eligible: `X_req_valid` && slot free. For fetch, also `f_flush`=0.
- Grant rule: fetch wins when both are eligible, unless `wait_cnt` >= `MAX_WAIT`, in which case debug wins. At most one grant per cycle.
- `X_req_ready` = 1 only for the granted requester, and is combinational.
- `wait_cnt` behaviour:
  - increments, saturating, each cycle `d_req_valid`=1 and debug is not granted;
  - clears on a debug grant;
  - clears when `d_req_valid`=0.
- `rom_addr` = granted requester's address with bits [1:0] forced to 0. It is 0 when there is no grant. `rom_instr` is sampled at the same edge.
- Error check: `err` = (addr[1:0] != 0) || (addr[31] == 0). On error the slot loads `instr`=0 and `err`=1; otherwise it loads `rom_instr` and `err`=0. An error still consumes the grant.
- Grant FSM, `gnt_state` (registered, records the grant of the previous cycle; used for debug/visibility):
  - states are IDLE, FETCH, DEBUG;
  - next state = FETCH if fetch is granted, DEBUG if debug is granted, else IDLE.
- Flush: `f_flush`=1 clears `f_rsp_valid` at the next edge, even if `f_rsp_ready`=0. Flush has priority over a slot load. Debug is unaffected.
- Simultaneous drain and load on one slot: the load wins, so `rsp_valid` stays 1 with the new data.

## Timing
- Reset (asserted low, asynchronous):
  - all `*_rsp_valid`, `*_rsp_err` and `*_rsp_instr` = 0;
  - `wait_cnt` = 0 and `gnt_state` = IDLE;
  - `rom_addr` = 0 and both `*_req_ready` = 0, because no grant is possible while reset is held.
  - Reset mid-access discards the in-flight response.
- Latency: request accepted at edge N gives `rsp_valid`=1 from edge N+1. Response data is stable until the edge where `rsp_ready`=1.
- Throughput: one access per cycle in total. A requester whose `rsp_ready` is held high can be served every cycle.
- Debug starvation bound: a continuously valid debug request with a free slot is granted within `MAX_WAIT`+1 cycles.

## Structure
- Package `imem_arb_pkg` holds:
  - the `gnt_state_t` enum (IDLE, FETCH, DEBUG);
  - `KSEG_BIT` = 31;
  - `ADDR_W` = 32 and `INSTR_W` = 32;
  - the NOP constant 32'h0000_0000.
- Sub-module `imem_rsp_slot` is instantiated twice. It is a one-entry holding register with ports `load`, `data`, `err`, `flush`, `rsp_valid`/`rsp_ready`, and reset behaviour as above.
- Grant logic and `wait_cnt` live in the top module.

## Test plan
- **Basic fetch:** fetch request 0x8000_0000 at cycle 1 with `rsp_ready`=1. Required: `f_rsp_valid` at cycle 2, `f_rsp_instr`=0x3C08_4000, `err`=0. Back-to-back 0x8000_0004 returns 0x8D09_0020 at cycle 3.
- **Error cases:**
  - fetch 0x0000_0000: `err`=1, `instr`=0;
  - fetch 0x8000_0002: `err`=1, and `rom_addr` is driven as 0x8000_0000 that cycle.
- **Contention:** fetch and debug both valid every cycle, `MAX_WAIT`=4. Required: debug is granted on its 5th pending cycle, `wait_cnt` returns to 0, and fetch resumes next cycle. Repeat and check the periodicity.
- **Backpressure:** `f_rsp_ready`=0 with the slot full. Required:
  - `f_req_ready`=0 and debug is granted instead;
  - the response stays stable for 3 cycles;
  - raising `f_rsp_ready` allows a same-cycle new grant, and `rsp_valid` stays 1 with the new data.
- **Flush:** flush with a pending unconsumed fetch response while a fetch request is valid. Required: `f_rsp_valid`=0 next cycle, no fetch grant that cycle, and the debug response is untouched.
- **Reset mid-operation:** assert `reset` low asynchronously between edges with both slots full. Required: all outputs read 0 immediately, and after release the first grant follows the normal priority rule.
